// File: rtl/ppu_issue_ctrl.sv
// Issue sequencer between EX-stage decode and the posit unit: latches operands,
// pulses one issue per op, waits for the result, handles flush and a watchdog.
module ppu_issue_ctrl #(
  parameter int unsigned OP_W    = 3,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             flush_i,
  output logic             ppu_valid_o,
  output logic [31:0]      ppu_in1_o,
  output logic [31:0]      ppu_in2_o,
  output logic [OP_W-1:0]  ppu_op_o,
  input  logic [31:0]      ppu_out_i,
  input  logic             ppu_valid_i,
  output logic [31:0]      result_o,
  output logic             ready_o,
  output logic             timeout_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] lat_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              to_flag, to_flag_nxt;
  logic [31:0]       in1_nxt, in2_nxt, result_nxt;
  logic [OP_W-1:0]   op_nxt;
  logic [CNT_W-1:0]  lat_nxt;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      to_flag   <= 1'b0;
      ppu_in1_o <= '0;
      ppu_in2_o <= '0;
      ppu_op_o  <= '0;
      result_o  <= '0;
      lat_o     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      to_flag   <= to_flag_nxt;
      ppu_in1_o <= in1_nxt;
      ppu_in2_o <= in2_nxt;
      ppu_op_o  <= op_nxt;
      result_o  <= result_nxt;
      lat_o     <= lat_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    to_flag_nxt = to_flag;
    in1_nxt     = ppu_in1_o;
    in2_nxt     = ppu_in2_o;
    op_nxt      = ppu_op_o;
    result_nxt  = result_o;
    lat_nxt     = lat_o;
    case (state)
      S_IDLE: begin
        if (req_i && !flush_i) begin
          in1_nxt     = op_a_i;
          in2_nxt     = op_b_i;
          op_nxt      = op_i;
          to_flag_nxt = 1'b0;
          state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_nxt = '0;
        if (flush_i) begin
          // A result arriving with the flush leaves nothing in flight to drain
          state_nxt = ppu_valid_i ? S_IDLE : S_DRAIN;
        end else if (ppu_valid_i) begin
          result_nxt = ppu_out_i;
          lat_nxt    = '0;
          state_nxt  = S_DONE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt + CNT_ONE;
        if (flush_i) begin
          if (ppu_valid_i) begin
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt   = '0;
            state_nxt = S_DRAIN;
          end
        end else if (ppu_valid_i) begin
          result_nxt = ppu_out_i;
          lat_nxt    = cnt + CNT_ONE;
          state_nxt  = S_DONE;
        end else if (cnt == CNT_LAST) begin
          result_nxt  = '0;
          to_flag_nxt = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        cnt_nxt = cnt + CNT_ONE;
        if (ppu_valid_i || (cnt == CNT_LAST)) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // A flush in DONE kills the completion, so ready is qualified by the live flush
  assign ppu_valid_o = (state == S_ISSUE);
  assign busy_o      = (state != S_IDLE);
  assign ready_o     = (state == S_DONE) && !flush_i;
  assign timeout_o   = ready_o && to_flag;

endmodule

// File: tb/tb_ppu_issue_ctrl.sv
// Directed bench for ppu_issue_ctrl: hand-timed vectors with immediate assertions.
module tb_ppu_issue_ctrl;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_i;
  logic [31:0]      op_a_i, op_b_i;
  logic [OP_W-1:0]  op_i;
  logic             flush_i;
  logic             ppu_valid_o;
  logic [31:0]      ppu_in1_o, ppu_in2_o;
  logic [OP_W-1:0]  ppu_op_o;
  logic [31:0]      ppu_out_i;
  logic             ppu_valid_i;
  logic [31:0]      result_o;
  logic             ready_o, timeout_o, busy_o;
  logic [CNT_W-1:0] lat_o;

  int n_pass  = 0;
  int n_total = 0;
  int n_issue = 0;
  int n_ready = 0;

  ppu_issue_ctrl #(.OP_W(OP_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .op_i(op_i), .flush_i(flush_i), .ppu_valid_o(ppu_valid_o),
    .ppu_in1_o(ppu_in1_o), .ppu_in2_o(ppu_in2_o), .ppu_op_o(ppu_op_o),
    .ppu_out_i(ppu_out_i), .ppu_valid_i(ppu_valid_i), .result_o(result_o),
    .ready_o(ready_o), .timeout_o(timeout_o), .busy_o(busy_o), .lat_o(lat_o)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (ppu_valid_o) n_issue++;
    if (ready_o)     n_ready++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [OP_W-1:0] op);
    req_i  = 1'b1;
    op_a_i = a;
    op_b_i = b;
    op_i   = op;
  endtask

  int issue0, ready0;

  initial begin
    rst = 1'b1; req_i = 1'b0; op_a_i = '0; op_b_i = '0; op_i = '0;
    flush_i = 1'b0; ppu_out_i = '0; ppu_valid_i = 1'b0;
    step(); step();
    check("rst_busy",   32'(busy_o), 32'd0);
    check("rst_valid",  32'(ppu_valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_in1",    ppu_in1_o, 32'd0);
    check("rst_lat",    32'(lat_o), 32'd0);
    rst = 1'b0;
    step();

    // 1: single op, unit latency 3
    issue0 = n_issue;
    start_op(32'h4000_0000, 32'h4000_0000, 3'd1);             // cycle 0
    step();                                                    // cycle 1
    check("t1_issue",  32'(ppu_valid_o), 32'd1);
    check("t1_in1",    ppu_in1_o, 32'h4000_0000);
    check("t1_in2",    ppu_in2_o, 32'h4000_0000);
    check("t1_op",     32'(ppu_op_o), 32'd1);
    step();                                                    // cycle 2
    check("t1_issue_once", 32'(ppu_valid_o), 32'd0);
    step();                                                    // cycle 3
    step();                                                    // cycle 4
    ppu_valid_i = 1'b1; ppu_out_i = 32'h4800_0000;
    check("t1_not_ready_c4", 32'(ready_o), 32'd0);
    step();                                                    // cycle 5
    ppu_valid_i = 1'b0; ppu_out_i = '0;
    check("t1_ready",   32'(ready_o), 32'd1);
    check("t1_timeout", 32'(timeout_o), 32'd0);
    check("t1_result",  result_o, 32'h4800_0000);
    check("t1_lat",     32'(lat_o), 32'd3);
    step();                                                    // cycle 6: req still high in DONE
    req_i = 1'b0;
    check("t1_no_reaccept", 32'(busy_o), 32'd0);
    step();
    check("t1_issue_count", 32'(n_issue - issue0), 32'd1);

    // 2: back-to-back, unit latency 0
    issue0 = n_issue; ready0 = n_ready;
    start_op(32'h1111_1111, 32'h2222_2222, 3'd2);             // cycle 0
    step();                                                    // cycle 1
    ppu_valid_i = 1'b1; ppu_out_i = 32'hAAAA_0001;
    step();                                                    // cycle 2
    ppu_valid_i = 1'b0;
    check("t2_ready1",  32'(ready_o), 32'd1);
    check("t2_result1", result_o, 32'hAAAA_0001);
    check("t2_lat1",    32'(lat_o), 32'd0);
    start_op(32'h3333_3333, 32'h4444_4444, 3'd3);
    step();                                                    // cycle 3: accept
    check("t2_gap_no_issue", 32'(ppu_valid_o), 32'd0);
    step();                                                    // cycle 4
    check("t2_issue2", 32'(ppu_valid_o), 32'd1);
    check("t2_in1_2",  ppu_in1_o, 32'h3333_3333);
    ppu_valid_i = 1'b1; ppu_out_i = 32'hBBBB_0002;
    step();                                                    // cycle 5
    ppu_valid_i = 1'b0; req_i = 1'b0;
    check("t2_ready2",  32'(ready_o), 32'd1);
    check("t2_result2", result_o, 32'hBBBB_0002);
    step();
    check("t2_issue_count", 32'(n_issue - issue0), 32'd2);
    check("t2_ready_count", 32'(n_ready - ready0), 32'd2);

    // 3: flush in WAIT at cnt=2, unit returns at L=6, next req waiting
    issue0 = n_issue; ready0 = n_ready;
    start_op(32'h5555_5555, 32'h6666_6666, 3'd4);             // cycle 0
    step(); step(); step(); step();                            // cycle 4, WAIT cnt=2
    flush_i = 1'b1; req_i = 1'b0;
    step();                                                    // cycle 5: DRAIN
    flush_i = 1'b0;
    start_op(32'h7777_7777, 32'h8888_8888, 3'd5);
    check("t3_drain_busy", 32'(busy_o), 32'd1);
    step();                                                    // cycle 6
    check("t3_drain_no_issue", 32'(ppu_valid_o), 32'd0);
    check("t3_in1_held", ppu_in1_o, 32'h5555_5555);
    step();                                                    // cycle 7
    ppu_valid_i = 1'b1; ppu_out_i = 32'hDEAD_BEEF;
    step();                                                    // cycle 8: IDLE, accepts
    ppu_valid_i = 1'b0;
    check("t3_idle_after_drain", 32'(busy_o), 32'd0);
    check("t3_result_kept", result_o, 32'hBBBB_0002);
    check("t3_no_ready", 32'(n_ready - ready0), 32'd0);
    step();                                                    // cycle 9: ISSUE
    check("t3_new_issue", 32'(ppu_valid_o), 32'd1);
    check("t3_new_in1", ppu_in1_o, 32'h7777_7777);
    ppu_valid_i = 1'b1; ppu_out_i = 32'h0000_0C0C;
    step();                                                    // cycle 10
    ppu_valid_i = 1'b0; req_i = 1'b0;
    check("t3_new_ready",  32'(ready_o), 32'd1);
    check("t3_new_result", result_o, 32'h0000_0C0C);
    step();
    check("t3_issue_count", 32'(n_issue - issue0), 32'd2);

    // 4: watchdog timeout
    start_op(32'h9999_9999, 32'h1, 3'd6);                      // cycle 0
    step();                                                    // cycle 1
    for (int i = 0; i < int'(TIMEOUT); i++) step();            // cycle 201
    check("t4_not_yet", 32'(ready_o), 32'd0);
    step();                                                    // cycle 202
    req_i = 1'b0;
    check("t4_ready",   32'(ready_o), 32'd1);
    check("t4_timeout", 32'(timeout_o), 32'd1);
    check("t4_result",  result_o, 32'd0);
    step();                                                    // cycle 203
    start_op(32'h0101_0101, 32'h0202_0202, 3'd1);
    step();                                                    // ISSUE
    step();                                                    // WAIT
    ppu_valid_i = 1'b1; ppu_out_i = 32'h1234_5678;
    step();                                                    // DONE
    ppu_valid_i = 1'b0; req_i = 1'b0;
    check("t4_next_ready",   32'(ready_o), 32'd1);
    check("t4_next_timeout", 32'(timeout_o), 32'd0);
    check("t4_next_result",  result_o, 32'h1234_5678);
    check("t4_next_lat",     32'(lat_o), 32'd1);
    step();

    // 5: reset in WAIT
    start_op(32'hCAFE_0000, 32'hCAFE_0001, 3'd2);
    step(); step();                                            // WAIT
    req_i = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_busy",   32'(busy_o), 32'd0);
    check("t5_result", result_o, 32'd0);
    check("t5_in1",    ppu_in1_o, 32'd0);
    check("t5_lat",    32'(lat_o), 32'd0);
    #2 rst = 1'b0;
    step();
    ppu_valid_i = 1'b1; ppu_out_i = 32'hFFFF_FFFF;
    step();
    ppu_valid_i = 1'b0;
    check("t5_spurious_ready",  32'(ready_o), 32'd0);
    check("t5_spurious_result", result_o, 32'd0);
    check("t5_spurious_busy",   32'(busy_o), 32'd0);

    // 6: flush together with valid in WAIT
    start_op(32'h1, 32'h2, 3'd3);
    step();
    ppu_valid_i = 1'b1; ppu_out_i = 32'h0BAD_F00D;
    step();
    ppu_valid_i = 1'b0; req_i = 1'b0;
    check("t6_pre_result", result_o, 32'h0BAD_F00D);
    step();
    start_op(32'h3, 32'h4, 3'd4);
    step(); step();                                            // WAIT
    ready0 = n_ready;
    flush_i = 1'b1; ppu_valid_i = 1'b1; ppu_out_i = 32'h5151_5151; req_i = 1'b0;
    step();
    flush_i = 1'b0; ppu_valid_i = 1'b0;
    check("t6_idle",   32'(busy_o), 32'd0);
    check("t6_result", result_o, 32'h0BAD_F00D);
    step();
    check("t6_no_ready", 32'(n_ready - ready0), 32'd0);

    // Flush landing on the DONE cycle suppresses ready
    start_op(32'h5, 32'h6, 3'd5);
    step();
    ppu_valid_i = 1'b1; ppu_out_i = 32'h7070_7070;
    step();                                                    // DONE
    ppu_valid_i = 1'b0; req_i = 1'b0; flush_i = 1'b1;
    #1;
    check("t7_ready_suppressed", 32'(ready_o), 32'd0);
    step();
    flush_i = 1'b0;
    check("t7_idle", 32'(busy_o), 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
